multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT, default 15, memory-wait cycles allowed before fault (range 1..255).
REQ-002 clk  input  1  rising-edge clock; only clock of the block.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26]; sampled in DECODE, may change at any other time.
REQ-005 zero  input  1  ALU zero flag; used in BRANCH only.
REQ-006 mem_ready  input  1  memory completion for the current mem_read/mem_write request.
REQ-007 Outputs, 1 bit each: pc_write, ir_write, iord (0=PC, 1=ALUOut address), mem_read, mem_write, reg_write, reg_dst (0=rt, 1=rd), mem_to_reg, alu_src_a (0=PC, 1=rs), pc_src (0=ALU result, 1=ALUOut).
REQ-008 alu_src_b  output  2  00=rt, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-009 alu_op  output  2  00=add, 01=subtract, 10=funct-decoded.
REQ-010 Status outputs: instr_done (1-bit retire pulse), illegal_op (1-bit pulse), fault (1 bit, sticky), instr_count (16 bits), state (4 bits).

Function
REQ-011 The block SHALL implement a multicycle FSM. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, FAULT=11. The state output SHALL equal the current encoding.
REQ-012 Any control output not listed for the current state SHALL be 0.
REQ-013 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. While mem_ready=0, the FSM holds in FETCH. In the mem_ready=1 cycle it asserts ir_write=1 and pc_write=1 with pc_src=0, then moves to DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. The FSM latches opcode internally. Next state: 0x00 to EXEC; 0x23 or 0x2B to MEMADR; 0x08 to ADDIEX; 0x04 or 0x05 to BRANCH. Any other opcode asserts illegal_op for 1 cycle and returns to FETCH, with no retire and no count.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for 0x23 and MEMWR for 0x2B.
REQ-016 MEMRD: mem_read=1, iord=1; it waits for mem_ready, then goes to MEMWB.
REQ-017 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then retire.
REQ-018 MEMWR: mem_write=1, iord=1; it waits for mem_ready, then retires.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then retire.
REQ-020 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; then retire.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1. pc_write = (latched opcode 0x04 AND zero) OR (latched opcode 0x05 AND NOT zero), evaluated combinationally. Then retire.
REQ-022 Retire: instr_done=1 in the final cycle of the instruction, instr_count increments (wrapping 0xFFFF to 0x0000), and the next state is FETCH.
REQ-023 Latency (mem_ready tied 1): R-type, addi and sw take 4 cycles. lw takes 5 cycles. beq/bne take 3 cycles.
REQ-024 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR. It increments on each cycle in which that state sees mem_ready=0.
REQ-025 When the wait counter equals TIMEOUT and mem_ready=0, the FSM SHALL enter FAULT instead of continuing to wait.
REQ-026 FAULT: all control outputs 0 and fault=1. The block leaves FAULT only on reset.
REQ-027 mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally, with no fault.
REQ-028 mem_ready=1 outside FETCH, MEMRD and MEMWR SHALL be ignored.

Reset
REQ-029 While reset=1: state=FETCH, instr_count=0, wait counter=0, fault=0, latched opcode=0. All combinational outputs follow FETCH with mem_ready masked, so ir_write, pc_write and reg_write are 0 and mem_write is 0.
REQ-030 Reset asserted mid-instruction SHALL abort with no further write strobes. The first cycle after deassertion is FETCH.

Verification
REQ-031 ready=1, opcode=0x00 -> states 0,1,6,7; reg_write and reg_dst=1 in cycle 4; instr_done once; instr_count=1.
REQ-032 opcode=0x23, ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; MEMWB has mem_to_reg=1 and reg_write=1; total 8 cycles.
REQ-033 opcode=0x04 with zero=1 -> pc_write=1 and pc_src=1 in BRANCH. opcode=0x05 with zero=1 -> pc_write=0 in BRANCH.
REQ-034 opcode=0x3F -> illegal_op pulse in DECODE; next state FETCH; instr_count unchanged; no reg_write or mem_write.
REQ-035 TIMEOUT=15, ready held 0 in FETCH -> FAULT after 16 FETCH cycles; fault=1 and strobes 0 until reset. A second run with ready=1 on the 16th cycle -> no fault.
REQ-036 Reset pulse during MEMWR -> mem_write drops immediately; after release the state is FETCH and instr_count=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: fetch/decode/execute FSM with memory-wait
// timeout, sticky fault state, retire pulse and retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic        pc_src,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        illegal_op,
    output logic        fault,
    output logic [15:0] instr_count,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_FAULT  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_opcode;
    logic [7:0]  r_wait;
    logic [15:0] r_count;
    logic        r_fault;
    logic        w_ready;
    logic        w_timeout;
    logic        w_waiting;
    logic        w_retire;

    // mem_ready is masked during reset so no strobe can fire while held in FETCH
    assign w_ready   = mem_ready & ~reset;
    assign w_timeout = (r_wait == LP_TIMEOUT);
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

    assign state       = r_state;
    assign instr_count = r_count;
    assign fault       = r_fault;
    assign instr_done  = w_retire;

    // Next-state and per-state control decode
    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        pc_src     = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (w_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_ADDI:       w_next = S_ADDIEX;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (r_opcode == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (r_opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FAULT;
                end
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (w_ready) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end else begin
                    w_next = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (w_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end else begin
                    w_next = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = ((r_opcode == OP_BEQ) & zero) | ((r_opcode == OP_BNE) & ~zero);
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_FAULT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is captured at the end of DECODE for MEMADR and BRANCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode <= 6'h00;
        end else if (r_state == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    // Memory-wait counter; any state change clears it, so it restarts on each wait entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= 8'd0;
        end else if (w_next != r_state) begin
            r_wait <= 8'd0;
        end else if (w_waiting && !mem_ready) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (w_retire) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Sticky fault flag, set on the transition into FAULT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_next == S_FAULT) begin
            r_fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: walks each instruction class,
// memory waits, timeout/fault, illegal opcode and mid-instruction reset.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic        reg_dst, mem_to_reg, alu_src_a, pc_src;
    logic [1:0]  alu_src_b, alu_op;
    logic        instr_done, illegal_op, fault;
    logic [15:0] instr_count;
    logic [3:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .illegal_op(illegal_op), .fault(fault), .instr_count(instr_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // Step past the next rising edge; inputs may then be changed and checks made mid-cycle
    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] exp_s);
        #1;
        chk(tag, 32'(state), 32'(exp_s));
    endtask

    // Run FETCH (ready=1) and DECODE for the given opcode, leaving the bench in the third cycle
    task automatic fetch_decode(input logic [5:0] op);
        mem_ready = 1'b1;
        opcode    = op;
        chk_state("fetch_state", 4'd0);
        adv();
        chk_state("decode_state", 4'd1);
        adv();
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        adv();
        adv();
        // Reset: FETCH with mem_ready masked
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd1);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        reset = 1'b0;

        // R-type: 0,1,6,7
        fetch_decode(6'h00);
        chk_state("r_exec", 4'd6);
        chk("r_exec_aluop", 32'(alu_op), 32'd2);
        adv();
        chk_state("r_rwb", 4'd7);
        chk("r_rwb_regwrite", 32'(reg_write), 32'd1);
        chk("r_rwb_regdst", 32'(reg_dst), 32'd1);
        chk("r_rwb_done", 32'(instr_done), 32'd1);
        adv();
        chk_state("r_back_fetch", 4'd0);
        chk("r_count", 32'(instr_count), 32'd1);

        // lw with 3 wait cycles in MEMRD (8 cycles total)
        fetch_decode(6'h23);
        chk_state("lw_memadr", 4'd2);
        chk("lw_memadr_srcb", 32'(alu_src_b), 32'd2);
        opcode = 6'h3F;
        adv();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_state("lw_memrd_wait", 4'd3);
            chk("lw_memrd_iord", 32'(iord), 32'd1);
            adv();
        end
        mem_ready = 1'b1;
        chk_state("lw_memrd_done", 4'd3);
        adv();
        mem_ready = 1'b0;
        chk_state("lw_memwb", 4'd4);
        chk("lw_memwb_m2r", 32'(mem_to_reg), 32'd1);
        chk("lw_memwb_regwrite", 32'(reg_write), 32'd1);
        chk("lw_memwb_done", 32'(instr_done), 32'd1);
        adv();
        chk("lw_count", 32'(instr_count), 32'd2);

        // beq taken, then zero flips low combinationally
        zero = 1'b1;
        fetch_decode(6'h04);
        chk_state("beq_branch", 4'd8);
        chk("beq_pcwrite", 32'(pc_write), 32'd1);
        chk("beq_pcsrc", 32'(pc_src), 32'd1);
        chk("beq_aluop", 32'(alu_op), 32'd1);
        zero = 1'b0;
        #1;
        chk("beq_nottaken", 32'(pc_write), 32'd0);
        adv();

        // bne with zero=1: not taken
        zero = 1'b1;
        fetch_decode(6'h05);
        chk_state("bne_branch", 4'd8);
        chk("bne_pcwrite", 32'(pc_write), 32'd0);
        chk("bne_done", 32'(instr_done), 32'd1);
        adv();
        chk("bne_count", 32'(instr_count), 32'd4);

        // sw: 4 cycles, retires in MEMWR
        fetch_decode(6'h2B);
        chk_state("sw_memadr", 4'd2);
        adv();
        chk_state("sw_memwr", 4'd5);
        chk("sw_memwrite", 32'(mem_write), 32'd1);
        chk("sw_done", 32'(instr_done), 32'd1);
        adv();
        chk("sw_count", 32'(instr_count), 32'd5);

        // addi
        fetch_decode(6'h08);
        chk_state("addi_ex", 4'd9);
        adv();
        chk_state("addi_wb", 4'd10);
        chk("addi_regwrite", 32'(reg_write), 32'd1);
        chk("addi_regdst", 32'(reg_dst), 32'd0);
        adv();
        chk("addi_count", 32'(instr_count), 32'd6);

        // Illegal opcode
        mem_ready = 1'b1;
        opcode = 6'h3F;
        chk_state("ill_fetch", 4'd0);
        adv();
        chk_state("ill_decode", 4'd1);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_regwrite", 32'(reg_write), 32'd0);
        chk("ill_memwrite", 32'(mem_write), 32'd0);
        adv();
        chk_state("ill_back_fetch", 4'd0);
        chk("ill_pulse_gone", 32'(illegal_op), 32'd0);
        chk("ill_count", 32'(instr_count), 32'd6);

        // Reset during MEMWR
        fetch_decode(6'h2B);
        adv();
        mem_ready = 1'b0;
        chk_state("rstw_memwr", 4'd5);
        chk("rstw_memwrite_on", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw_memwrite_off", 32'(mem_write), 32'd0);
        chk("rstw_state", 32'(state), 32'd0);
        adv();
        reset = 1'b0;
        chk_state("rstw_after", 4'd0);
        chk("rstw_count", 32'(instr_count), 32'd0);

        // Timeout: 16 FETCH cycles with ready low, then FAULT
        for (int i = 0; i < 16; i++) begin
            chk_state("to_fetch", 4'd0);
            adv();
        end
        chk_state("to_fault", 4'd11);
        chk("to_fault_flag", 32'(fault), 32'd1);
        chk("to_fault_memread", 32'(mem_read), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("to_fault_pcwrite", 32'(pc_write), 32'd0);
        chk("to_fault_irwrite", 32'(ir_write), 32'd0);
        adv();
        chk_state("to_fault_sticky", 4'd11);
        reset = 1'b1;
        mem_ready = 1'b0;
        adv();
        reset = 1'b0;
        chk_state("to_reset_exit", 4'd0);
        chk("to_reset_fault", 32'(fault), 32'd0);

        // Ready arriving on the 16th cycle completes normally
        for (int i = 0; i < 15; i++) begin
            adv();
        end
        mem_ready = 1'b1;
        chk_state("edge_fetch16", 4'd0);
        chk("edge_irwrite", 32'(ir_write), 32'd1);
        adv();
        chk_state("edge_decode", 4'd1);
        chk("edge_nofault", 32'(fault), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
